lfsr_checker: RTL

Receive-side counterpart of the team's 16-bit Fibonacci LFSR pseudorandom generator. It consumes the generator's sampled output words, self-synchronises to the sequence, then verifies every later word against its own prediction. It reports lock status and counts mismatches. Used as a bring-up/BIST monitor for the pong randomness path, e.g. ball serve angle and speed.

---
 rtl/lfsr_checker.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/lfsr_checker.sv
// Receive-side monitor for the 16-bit Fibonacci LFSR generator: seeds from the
// incoming words, locks after a run of correct predictions, then counts mispredictions.
module lfsr_checker #(
    parameter int LOCK_COUNT = 4,
    parameter int LOSS_COUNT = 3,
    parameter int ERR_W      = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [15:0]      in_data,
    input  logic             clear_errs,
    output logic             locked,
    output logic             error_pulse,
    output logic             zero_pulse,
    output logic [ERR_W-1:0] err_count
);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam logic [3:0] LOCK_C = 4'(LOCK_COUNT);
    localparam logic [3:0] LOSS_C = 4'(LOSS_COUNT);

    // Generator successor: x^16+x^14+x^13+x^11+1, right-shifting, feedback into bit 15.
    function automatic logic [15:0] lfsr_nxt(input logic [15:0] s);
        return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
    endfunction

    state_t           state_q, state_d;
    logic [15:0]      expected_q, expected_d;
    logic [3:0]       run_q, run_d;
    logic [3:0]       bad_q, bad_d;
    logic             locked_q, locked_d;
    logic             error_pulse_q, error_pulse_d;
    logic             zero_pulse_q, zero_pulse_d;
    logic [ERR_W-1:0] err_count_q, err_count_d;
    logic             err_inc_s;
    logic             is_zero_s;
    logic             is_match_s;
    logic [3:0]       run_inc_s;
    logic [3:0]       bad_inc_s;

    assign is_zero_s  = (in_data == 16'h0000);
    assign is_match_s = (in_data == expected_q);
    assign run_inc_s  = run_q + 4'd1;
    assign bad_inc_s  = bad_q + 4'd1;

    // Next-state decode; only a valid word moves the sequence state.
    always_comb begin
        state_d       = state_q;
        expected_d    = expected_q;
        run_d         = run_q;
        bad_d         = bad_q;
        locked_d      = locked_q;
        error_pulse_d = 1'b0;
        zero_pulse_d  = 1'b0;
        err_inc_s     = 1'b0;
        if (in_valid) begin
            case (state_q)
                SEARCH: begin
                    if (is_zero_s) begin
                        zero_pulse_d = 1'b1;
                    end else begin
                        expected_d = lfsr_nxt(in_data);
                        run_d      = 4'd0;
                        state_d    = VERIFY;
                    end
                end
                VERIFY: begin
                    if (is_zero_s) begin
                        zero_pulse_d = 1'b1;
                        run_d        = 4'd0;
                        state_d      = SEARCH;
                    end else if (is_match_s) begin
                        expected_d = lfsr_nxt(in_data);
                        run_d      = run_inc_s;
                        if (run_inc_s == LOCK_C) begin
                            state_d  = LOCKED;
                            locked_d = 1'b1;
                            bad_d    = 4'd0;
                        end else begin
                            state_d = VERIFY;
                        end
                    end else begin
                        // Reseed from the offending word rather than waiting for the old chain.
                        expected_d = lfsr_nxt(in_data);
                        run_d      = 4'd0;
                    end
                end
                LOCKED: begin
                    expected_d = lfsr_nxt(expected_q);
                    if (is_match_s) begin
                        bad_d = 4'd0;
                    end else begin
                        error_pulse_d = 1'b1;
                        zero_pulse_d  = is_zero_s;
                        err_inc_s     = 1'b1;
                        bad_d         = bad_inc_s;
                        if (bad_inc_s == LOSS_C) begin
                            state_d  = SEARCH;
                            locked_d = 1'b0;
                            run_d    = 4'd0;
                        end else begin
                            state_d = LOCKED;
                        end
                    end
                end
                default: begin
                    state_d  = SEARCH;
                    locked_d = 1'b0;
                    run_d    = 4'd0;
                    bad_d    = 4'd0;
                end
            endcase
        end else begin
            state_d = state_q;
        end
        err_count_d = clear_errs ? '0 :
                      (err_inc_s && (err_count_q != '1)) ? err_count_q + ERR_W'(1) :
                      err_count_q;
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= SEARCH;
            expected_q    <= 16'h0000;
            run_q         <= 4'd0;
            bad_q         <= 4'd0;
            locked_q      <= 1'b0;
            error_pulse_q <= 1'b0;
            zero_pulse_q  <= 1'b0;
            err_count_q   <= '0;
        end else begin
            state_q       <= state_d;
            expected_q    <= expected_d;
            run_q         <= run_d;
            bad_q         <= bad_d;
            locked_q      <= locked_d;
            error_pulse_q <= error_pulse_d;
            zero_pulse_q  <= zero_pulse_d;
            err_count_q   <= err_count_d;
        end
    end

    assign locked      = locked_q;
    assign error_pulse = error_pulse_q;
    assign zero_pulse  = zero_pulse_q;
    assign err_count   = err_count_q;

endmodule
